// File: rtl/shared_adder_rr_if.sv
// Request/result bundle for shared_adder_rr: NUM_CH operand ports in, one tagged result out.
// Handshake: a transfer happens on any cycle where valid and ready are both high at the clock
// edge; a producer holds its payload stable until that transfer and never derives valid from ready.
interface shared_adder_rr_if #(
  parameter int add_bit = 4,
  parameter int NUM_CH  = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_ready;
  logic [NUM_CH*add_bit-1:0] in_a;
  logic [NUM_CH*add_bit-1:0] in_b;
  logic [NUM_CH-1:0]         in_sub;
  logic                      out_valid;
  logic                      out_ready;
  logic [add_bit-1:0]        out_sum;
  logic                      out_carry;
  logic [CH_W-1:0]           out_ch;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ch
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ch
  );
endinterface

// File: rtl/shared_adder_rr.sv
// One add/subtract unit time-shared by NUM_CH requesters under round-robin arbitration.
// The result is registered with its channel tag and drained through a valid/ready port.
module shared_adder_rr #(
  parameter  int add_bit = 4,
  parameter  int NUM_CH  = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic              clk,
  input logic              reset,
  shared_adder_rr_if.slave bus
);

  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    grant_idx;
  logic [CH_W-1:0]    ptr_next;
  logic               found;
  logic               slot_free;
  logic               take;
  logic [NUM_CH-1:0]  ready;
  logic [add_bit-1:0] op_a;
  logic [add_bit-1:0] op_b;
  logic               op_sub;
  logic [add_bit:0]   result;

  logic               out_valid_q;
  logic [add_bit-1:0] sum_q;
  logic               carry_q;
  logic [CH_W-1:0]    ch_q;

  assign slot_free = !out_valid_q || bus.out_ready;

  // Two passes give the wrap-around scan: first rr_ptr..NUM_CH-1, then 0..rr_ptr-1.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && (i >= int'(rr_ptr)) && bus.in_valid[i]) begin
        found     = 1'b1;
        grant_idx = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && (i < int'(rr_ptr)) && bus.in_valid[i]) begin
        found     = 1'b1;
        grant_idx = CH_W'(i);
      end
    end
  end

  // Reset gates the grant so no transfer is offered while state is being cleared.
  assign take = found && slot_free && !reset;

  always_comb begin
    ready  = '0;
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) begin
        ready[i] = take;
        op_a     = bus.in_a[i*add_bit +: add_bit];
        op_b     = bus.in_b[i*add_bit +: add_bit];
        op_sub   = bus.in_sub[i];
      end
    end
  end

  // Subtraction as A + ~B + 1, so the carry out reads as "no borrow".
  assign result = {1'b0, op_a}
                + {1'b0, (op_sub ? ~op_b : op_b)}
                + {{add_bit{1'b0}}, op_sub};

  assign ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ch_q        <= '0;
    end else begin
      if (take) begin
        rr_ptr      <= ptr_next;
        out_valid_q <= 1'b1;
        sum_q       <= result[add_bit-1:0];
        carry_q     <= result[add_bit];
        ch_q        <= grant_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
  assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_shared_adder_rr.sv
// Directed bench for shared_adder_rr: a 4-channel and a 1-channel instance on one clock,
// checked against hand-computed vector tables and short multi-cycle sequences.
module tb_shared_adder_rr;
  localparam int AW = 4;
  localparam int NC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  shared_adder_rr_if #(.add_bit(AW), .NUM_CH(NC)) bus  ();
  shared_adder_rr_if #(.add_bit(AW), .NUM_CH(1))  bus1 ();

  shared_adder_rr #(.add_bit(AW), .NUM_CH(NC)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  shared_adder_rr #(.add_bit(AW), .NUM_CH(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          sub;
    logic [AW-1:0] sum;
    logic          carry;
  } vec_t;

  vec_t vecs[7];
  vec_t vecs1[4];

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_e;
  logic [1:0] g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [AW-1:0] s,
                           input logic c, input logic [1:0] ch);
    chk({tag, "_valid"}, bus.out_valid, v);
    chk({tag, "_sum"},   bus.out_sum,   s);
    chk({tag, "_carry"}, bus.out_carry, c);
    chk({tag, "_ch"},    bus.out_ch,    ch);
  endtask

  task automatic chk_pop(input string tag);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got result with empty expected queue, expected none", tag);
    end else begin
      n_checks--;
      exp_e = exp_q.pop_front();
      chk({tag, "_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_ch"},    bus.out_ch,    exp_e[5:4]);
      chk({tag, "_sum"},   bus.out_sum,   exp_e[3:0]);
    end
  endtask

  task automatic set_op(input int ch, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic sub);
    bus.in_a[ch*AW +: AW] = a;
    bus.in_b[ch*AW +: AW] = b;
    bus.in_sub[ch]        = sub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{4'd9,  4'd8,  1'b0, 4'd1,  1'b1};
    vecs[1] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};
    vecs[2] = '{4'd5,  4'd7,  1'b1, 4'd14, 1'b0};
    vecs[3] = '{4'd7,  4'd7,  1'b1, 4'd0,  1'b1};
    vecs[4] = '{4'd3,  4'd4,  1'b0, 4'd7,  1'b0};
    vecs[5] = '{4'd0,  4'd1,  1'b1, 4'd15, 1'b0};
    vecs[6] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1};

    vecs1[0] = '{4'd1,  4'd2,  1'b0, 4'd3,  1'b0};
    vecs1[1] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
    vecs1[2] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1};
    vecs1[3] = '{4'd6,  4'd3,  1'b1, 4'd3,  1'b1};

    bus.in_valid   = '0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_sub     = '0;
    bus.out_ready  = 1'b1;
    bus1.in_valid  = '0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_sub    = '0;
    bus1.out_ready = 1'b1;

    // Reset with every channel requesting: nothing may be granted.
    #2;
    reset         = 1'b1;
    bus.in_valid  = 4'hF;
    bus1.in_valid = 1'b1;
    #1;
    check_out("reset", 1'b0, 4'd0, 1'b0, 2'd0);
    chk("reset_in_ready",   bus.in_ready,   4'b0000);
    chk("reset1_in_ready",  bus1.in_ready,  1'b0);
    chk("reset1_out_valid", bus1.out_valid, 1'b0);
    tick();
    reset         = 1'b0;
    bus.in_valid  = '0;
    bus1.in_valid = '0;

    // Arithmetic table on ch0, back-to-back with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      set_op(0, vecs[i].a, vecs[i].b, vecs[i].sub);
      bus.in_valid = 4'b0001;
      @(negedge clk);
      chk($sformatf("arith%0d_ready", i), bus.in_ready, 4'b0001);
      tick();
      check_out($sformatf("arith%0d", i), 1'b1, vecs[i].sum, vecs[i].carry, 2'd0);
    end
    bus.in_valid = '0;

    // Single-channel build: four consecutive results, tag always 0.
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.in_a   = vecs1[i].a;
      bus1.in_b   = vecs1[i].b;
      bus1.in_sub = vecs1[i].sub;
      @(negedge clk);
      chk($sformatf("one%0d_ready", i), bus1.in_ready, 1'b1);
      tick();
      chk($sformatf("one%0d_valid", i), bus1.out_valid, 1'b1);
      chk($sformatf("one%0d_sum", i),   bus1.out_sum,   vecs1[i].sum);
      chk($sformatf("one%0d_carry", i), bus1.out_carry, vecs1[i].carry);
      chk($sformatf("one%0d_ch", i),    bus1.out_ch,    1'b0);
    end
    bus1.in_valid = 1'b0;
    tick();
    chk("one_drain_valid", bus1.out_valid, 1'b0);

    // Fresh pointer, then all four channels requesting for 8 cycles.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int c = 0; c < NC; c++) set_op(c, 4'(c + 1), 4'(c), 1'b0);
    bus.in_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({2'(k % 4), 4'(2 * (k % 4) + 1)});
      @(negedge clk);
      chk($sformatf("rr%0d_ready", k), bus.in_ready, 4'b0001 << (k % 4));
      tick();
      chk_pop($sformatf("rr%0d", k));
    end

    // Sparse: only ch1 and ch3, pointer wraps from 3 back to 1.
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2'd1 : 2'd3;
      exp_q.push_back({g, 4'(2 * g + 1)});
      @(negedge clk);
      chk($sformatf("sparse%0d_ready", k), bus.in_ready, 4'b0001 << g);
      tick();
      chk_pop($sformatf("sparse%0d", k));
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    // Drain with nothing requesting: valid drops, payload holds.
    bus.in_valid = '0;
    tick();
    check_out("drain", 1'b0, 4'd7, 1'b0, 2'd3);

    // Backpressure: load, stall three cycles, then drain and reload together.
    set_op(0, 4'd2, 4'd3, 1'b0);
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_load_ready", bus.in_ready, 4'b0001);
    tick();
    check_out("bp_load", 1'b1, 4'd5, 1'b0, 2'd0);
    set_op(0, 4'd12, 4'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_ready", k), bus.in_ready, 4'b0000);
      tick();
      check_out($sformatf("bp_stall%0d", k), 1'b1, 4'd5, 1'b0, 2'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_reload_ready", bus.in_ready, 4'b0001);
    tick();
    check_out("bp_reload", 1'b1, 4'd10, 1'b1, 2'd0);
    bus.in_valid = '0;
    tick();
    check_out("bp_drain", 1'b0, 4'd10, 1'b1, 2'd0);

    // Reset in the middle of a stall discards the held result.
    set_op(3, 4'd15, 4'd2, 1'b0);
    set_op(2, 4'd3,  4'd2, 1'b0);
    bus.in_valid  = 4'b1000;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("ms_load_ready", bus.in_ready, 4'b1000);
    tick();
    check_out("ms_load", 1'b1, 4'd1, 1'b1, 2'd3);
    bus.in_valid = '0;
    tick();
    check_out("ms_hold", 1'b1, 4'd1, 1'b1, 2'd3);
    bus.in_valid = 4'hF;
    reset        = 1'b1;
    #1;
    check_out("ms_reset", 1'b0, 4'd0, 1'b0, 2'd0);
    chk("ms_reset_ready", bus.in_ready, 4'b0000);
    #1;
    reset         = 1'b0;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ms_first_ready", bus.in_ready, 4'b0100);
    tick();
    check_out("ms_first", 1'b1, 4'd5, 1'b0, 2'd2);
    bus.in_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
